// File: rtl/downscale_pkg.sv
// ----------------------------------------------------------------------------
// downscale_pkg
// Shared types for the downscaler output path.
//   state_e : pack-writer control states (RUN / FLUSH / DRAIN)
//   word_t  : one packed memory word (word address, 4 data lanes, byte enables)
// The word address field is sized for the widest supported pixel address
// (64-bit byte address); narrower instances zero-extend into it.
// ----------------------------------------------------------------------------
package downscale_pkg;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      DRAIN
   } state_e;

   localparam int DEFAULT_FIFO_DEPTH = 4;
   localparam int WORD_ADDR_MAX_W    = 62;

   typedef struct packed {
      logic [WORD_ADDR_MAX_W-1:0] addr;
      logic [31:0]                data;
      logic [3:0]                 be;
   } word_t;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// head_data whenever empty is low; a push and a pop in the same cycle on a
// full FIFO are both accepted and leave the count unchanged.
//   clk, rst_n         : clock, asynchronous active-low reset
//   push, push_data    : write request and data (ignored when full without pop)
//   pop                : remove head entry (ignored when empty)
//   head_data          : current head entry
//   full, empty, count : occupancy status
// DEPTH must be a power of two, >= 2, so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; entries are only observable
   // once written, because empty is derived from the reset count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/pixel_pack_writer.sv
// ----------------------------------------------------------------------------
// pixel_pack_writer
// Packs a non-stallable stream of 8-bit output pixels into 32-bit
// little-endian memory words with byte enables, buffers them in a small FWFT
// FIFO, and drains everything on a flush pulse.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   pix_valid, pix_addr, pix_data : one pixel per cycle (byte address, value)
//   flush                         : pulse; emit partial word then drain
//   mem_valid, mem_ready          : word handshake toward memory
//   mem_addr, mem_data, mem_be    : word address, packed lanes, byte enables
//   busy                          : anything pending or not in RUN
//   flushed                       : one-cycle pulse when a flush completes
//   overflow                      : sticky, a pixel or word was dropped
// ADDR_W may be at most 64.
// ----------------------------------------------------------------------------
module pixel_pack_writer
   import downscale_pkg::*;
#(
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pix_valid,
   input  logic [ADDR_W-1:0] pix_addr,
   input  logic [7:0]        pix_data,
   input  logic              flush,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_data,
   output logic [3:0]        mem_be,
   output logic              busy,
   output logic              flushed,
   output logic              overflow
);

   localparam int WA_W  = ADDR_W - 2;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_e          state_q, state_d;
   logic [WA_W-1:0] buf_addr_q, buf_addr_d;
   logic [31:0]     buf_data_q, buf_data_d;
   logic [3:0]      buf_mask_q, buf_mask_d;
   logic            overflow_q, overflow_d;

   logic [WA_W-1:0] pix_waddr;
   logic [1:0]      pix_lane;
   logic [3:0]      lane_sel;
   logic            buf_empty, buf_hit;
   logic [31:0]     fresh_data, merged_data;
   logic [3:0]      merged_mask;
   logic            push_req, push, pop;
   word_t           push_word, head_word;
   logic            fifo_full, fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic            unused_head_addr;

   function automatic word_t make_word(input logic [WA_W-1:0] addr,
                                       input logic [31:0]     data,
                                       input logic [3:0]      be);
      word_t w;
      w.addr = WORD_ADDR_MAX_W'(addr);
      w.data = data;
      w.be   = be;
      return w;
   endfunction

   assign pix_waddr = pix_addr[ADDR_W-1:2];
   assign pix_lane  = pix_addr[1:0];
   assign lane_sel  = 4'b0001 << pix_lane;
   assign buf_empty = (buf_mask_q == 4'h0);
   // An empty buffer accepts any word address.
   assign buf_hit   = buf_empty || (buf_addr_q == pix_waddr);
   assign pop       = mem_valid && mem_ready;

   // Lanes not written since the buffer was loaded read back as zero.
   always_comb begin
      fresh_data  = '0;
      merged_data = buf_empty ? '0 : buf_data_q;
      for (int k = 0; k < 4; k++) begin
         if (pix_lane == 2'(k)) begin
            fresh_data[8*k +: 8]  = pix_data;
            merged_data[8*k +: 8] = pix_data;
         end
      end
      merged_mask = buf_mask_q | lane_sel;
   end

   always_comb begin
      state_d    = state_q;
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      buf_mask_d = buf_mask_q;
      overflow_d = overflow_q;
      push_req   = 1'b0;
      push_word  = make_word(buf_addr_q, buf_data_q, buf_mask_q);
      flushed    = 1'b0;

      case (state_q)
         RUN: begin
            if (pix_valid) begin
               if (buf_hit) begin
                  if (merged_mask == 4'hF) begin
                     // Completed word goes straight to the FIFO.
                     push_req   = 1'b1;
                     push_word  = make_word(pix_waddr, merged_data, merged_mask);
                     buf_mask_d = 4'h0;
                  end else begin
                     buf_addr_d = pix_waddr;
                     buf_data_d = merged_data;
                     buf_mask_d = merged_mask;
                  end
               end else begin
                  // Word address changed: retire the old partial word.
                  push_req   = 1'b1;
                  buf_addr_d = pix_waddr;
                  buf_data_d = fresh_data;
                  buf_mask_d = lane_sel;
               end
            end
            if (flush) state_d = FLUSH;
         end
         FLUSH: begin
            if (pix_valid) overflow_d = 1'b1;
            if (buf_empty) begin
               state_d = DRAIN;
            end else if (!fifo_full || pop) begin
               push_req   = 1'b1;
               buf_mask_d = 4'h0;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            if (pix_valid) overflow_d = 1'b1;
            if (fifo_empty) begin
               flushed = 1'b1;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase

      if (push_req && fifo_full && !pop) overflow_d = 1'b1;
      push = push_req && (!fifo_full || pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         buf_addr_q <= '0;
         buf_data_q <= '0;
         buf_mask_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_addr_q <= buf_addr_d;
         buf_data_q <= buf_data_d;
         buf_mask_q <= buf_mask_d;
         overflow_q <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH($bits(word_t)),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_data(push_word),
      .pop      (pop),
      .head_data(head_word),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Outputs are forced to zero while the FIFO is empty so that unwritten
   // storage never reaches the memory port.
   assign mem_valid = !fifo_empty;
   assign mem_addr  = fifo_empty ? '0 : head_word.addr[WA_W-1:0];
   assign mem_data  = fifo_empty ? '0 : head_word.data;
   assign mem_be    = fifo_empty ? '0 : head_word.be;
   assign busy      = (state_q != RUN) || !buf_empty || (fifo_count != '0);
   assign overflow  = overflow_q;

   // Upper word-address bits are always zero for this ADDR_W.
   assign unused_head_addr = ^head_word.addr;

endmodule

// File: tb/tb_pixel_pack_writer.sv
module tb_pixel_pack_writer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pix_valid = 1'b0;
   logic [AW-1:0] pix_addr = '0;
   logic [7:0]    pix_data = '0;
   logic          flush = 1'b0;
   logic          mem_ready = 1'b0;
   logic          mem_valid;
   logic [AW-3:0] mem_addr;
   logic [31:0]   mem_data;
   logic [3:0]    mem_be;
   logic          busy, flushed, overflow;

   int n_vec = 0;
   int n_err = 0;
   int xfers = 0;

   always #5 clk = ~clk;

   pixel_pack_writer #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_addr(pix_addr),
      .pix_data(pix_data), .flush(flush), .mem_valid(mem_valid),
      .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_be(mem_be), .busy(busy), .flushed(flushed), .overflow(overflow)
   );

   // ---------------- reference model ----------------
   typedef enum {M_RUN, M_FLUSH, M_DRAIN} mstate_e;
   typedef struct {
      logic [AW-3:0] addr;
      logic [31:0]   data;
      logic [3:0]    be;
   } mword_t;

   mword_t        mq[$];
   mstate_e       m_state;
   logic [AW-3:0] m_baddr;
   logic [31:0]   m_bdata;
   logic [3:0]    m_mask;
   logic          m_ov;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_state = M_RUN;
      m_baddr = '0;
      m_bdata = '0;
      m_mask  = '0;
      m_ov    = 1'b0;
   endtask

   task automatic model_check();
      check("mem_valid", mem_valid, 64'(mq.size() > 0));
      if (mq.size() > 0) begin
         check("mem_addr", mem_addr, mq[0].addr);
         check("mem_data", mem_data, mq[0].data);
         check("mem_be", mem_be, mq[0].be);
      end
      check("busy", busy, 64'(m_state != M_RUN || m_mask != 0 || mq.size() != 0));
      check("flushed", flushed, 64'(m_state == M_DRAIN && mq.size() == 0));
      check("overflow", overflow, m_ov);
   endtask

   task automatic model_edge(input logic pv, input logic [AW-1:0] pa, input logic [7:0] pd,
                             input logic fl, input logic rdy);
      bit            pop, have_push;
      mword_t        pw;
      logic [AW-3:0] waddr;
      int            lane;
      pop       = rdy && (mq.size() > 0);
      have_push = 0;
      pw        = '{default: '0};
      waddr     = pa[AW-1:2];
      lane      = int'(pa[1:0]);
      case (m_state)
         M_RUN: begin
            if (pv) begin
               if (m_mask != 0 && m_baddr != waddr) begin
                  pw = '{m_baddr, m_bdata, m_mask};
                  have_push = 1;
                  m_mask = '0;
               end
               if (m_mask == 0) begin
                  m_baddr = waddr;
                  m_bdata = '0;
               end
               m_bdata[lane*8 +: 8] = pd;
               m_mask[lane] = 1'b1;
               if (m_mask == 4'hF) begin
                  pw = '{m_baddr, m_bdata, m_mask};
                  have_push = 1;
                  m_mask = '0;
               end
            end
            if (fl) m_state = M_FLUSH;
         end
         M_FLUSH: begin
            if (pv) m_ov = 1'b1;
            if (m_mask == 0) begin
               m_state = M_DRAIN;
            end else if (mq.size() - (pop ? 1 : 0) < DEPTH) begin
               pw = '{m_baddr, m_bdata, m_mask};
               have_push = 1;
               m_mask = '0;
               m_state = M_DRAIN;
            end
         end
         M_DRAIN: begin
            if (pv) m_ov = 1'b1;
            if (mq.size() == 0) m_state = M_RUN;
         end
         default: ;
      endcase
      if (pop) void'(mq.pop_front());
      if (have_push) begin
         if (mq.size() < DEPTH) mq.push_back(pw);
         else m_ov = 1'b1;
      end
   endtask

   // ---------------- cycle helpers ----------------
   task automatic sample_phase();
      @(negedge clk);
      model_check();
      if (mem_valid && mem_ready) xfers++;
   endtask

   task automatic edge_phase();
      @(posedge clk);
      model_edge(pix_valid, pix_addr, pix_data, flush, mem_ready);
      #1;
   endtask

   task automatic step(input logic pv, input logic [AW-1:0] pa, input logic [7:0] pd,
                       input logic fl, input logic rdy);
      pix_valid = pv;
      pix_addr  = pa;
      pix_data  = pd;
      flush     = fl;
      mem_ready = rdy;
      sample_phase();
      edge_phase();
   endtask

   task automatic do_reset();
      pix_valid = 1'b0;
      flush     = 1'b0;
      mem_ready = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      check("rst_mem_valid", mem_valid, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_mem_be", mem_be, 0);
      check("rst_busy", busy, 0);
      check("rst_flushed", flushed, 0);
      check("rst_overflow", overflow, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic          pv;
      logic [7:0]    pa;
      logic [7:0]    pd;
      logic          fl;
      logic          e_valid;
      logic [AW-3:0] e_addr;
      logic [3:0]    e_be;
      logic [31:0]   e_data;
      logic          e_busy;
      logic          e_flushed;
   } vec_t;

   function automatic vec_t mk(logic pv, logic [7:0] pa, logic [7:0] pd, logic fl,
                               logic ev, logic [AW-3:0] ea, logic [3:0] eb,
                               logic [31:0] ed, logic ebusy, logic efl);
      vec_t v;
      v = '{pv, pa, pd, fl, ev, ea, eb, ed, ebusy, efl};
      return v;
   endfunction

   vec_t tbl[20];

   initial begin
      logic [AW-1:0] seq;
      int            r;

      model_reset();

      // Split word (addr 5 then 12), flush; pair at 0/1 with flush in the
      // same cycle; repeated lane 3 overwritten, then flush.
      tbl[0]  = mk(1, 8'd5,  8'hAA, 0, 0, 0, 4'h0, 32'h0,        0, 0);
      tbl[1]  = mk(1, 8'd12, 8'hBB, 0, 0, 0, 4'h0, 32'h0,        1, 0);
      tbl[2]  = mk(0, 8'd0,  8'h00, 1, 1, 1, 4'h2, 32'h0000AA00, 1, 0);
      tbl[3]  = mk(0, 8'd0,  8'h00, 0, 0, 0, 4'h0, 32'h0,        1, 0);
      tbl[4]  = mk(0, 8'd0,  8'h00, 0, 1, 3, 4'h1, 32'h000000BB, 1, 0);
      tbl[5]  = mk(0, 8'd0,  8'h00, 0, 0, 0, 4'h0, 32'h0,        1, 1);
      tbl[6]  = mk(0, 8'd0,  8'h00, 0, 0, 0, 4'h0, 32'h0,        0, 0);
      tbl[7]  = mk(1, 8'd0,  8'h11, 0, 0, 0, 4'h0, 32'h0,        0, 0);
      tbl[8]  = mk(1, 8'd1,  8'h22, 1, 0, 0, 4'h0, 32'h0,        1, 0);
      tbl[9]  = mk(0, 8'd0,  8'h00, 0, 0, 0, 4'h0, 32'h0,        1, 0);
      tbl[10] = mk(0, 8'd0,  8'h00, 0, 1, 0, 4'h3, 32'h00002211, 1, 0);
      tbl[11] = mk(0, 8'd0,  8'h00, 0, 0, 0, 4'h0, 32'h0,        1, 1);
      tbl[12] = mk(0, 8'd0,  8'h00, 0, 0, 0, 4'h0, 32'h0,        0, 0);
      tbl[13] = mk(1, 8'd3,  8'hAA, 0, 0, 0, 4'h0, 32'h0,        0, 0);
      tbl[14] = mk(1, 8'd3,  8'hBB, 0, 0, 0, 4'h0, 32'h0,        1, 0);
      tbl[15] = mk(0, 8'd0,  8'h00, 1, 0, 0, 4'h0, 32'h0,        1, 0);
      tbl[16] = mk(0, 8'd0,  8'h00, 0, 0, 0, 4'h0, 32'h0,        1, 0);
      tbl[17] = mk(0, 8'd0,  8'h00, 0, 1, 0, 4'h8, 32'hBB000000, 1, 0);
      tbl[18] = mk(0, 8'd0,  8'h00, 0, 0, 0, 4'h0, 32'h0,        1, 1);
      tbl[19] = mk(0, 8'd0,  8'h00, 0, 0, 0, 4'h0, 32'h0,        0, 0);

      do_reset();
      for (int i = 0; i < 20; i++) begin
         pix_valid = tbl[i].pv;
         pix_addr  = AW'(tbl[i].pa);
         pix_data  = tbl[i].pd;
         flush     = tbl[i].fl;
         mem_ready = 1'b1;
         sample_phase();
         check($sformatf("tbl%0d_valid", i), mem_valid, tbl[i].e_valid);
         if (tbl[i].e_valid) begin
            check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_be", i), mem_be, tbl[i].e_be);
            check($sformatf("tbl%0d_data", i), mem_data, tbl[i].e_data);
         end
         check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
         check($sformatf("tbl%0d_flushed", i), flushed, tbl[i].e_flushed);
         edge_phase();
      end

      // 256 sequential pixels with memory always ready.
      do_reset();
      xfers = 0;
      for (int i = 0; i < 256; i++) begin
         step(1'b1, AW'(i), 8'(i), 1'b0, 1'b1);
         if (i == 2) check("seq_not_yet_valid", mem_valid, 0);
         if (i == 3) begin
            check("seq_first_valid", mem_valid, 1);
            check("seq_first_data", mem_data, 32'h03020100);
         end
      end
      for (int i = 0; i < 4; i++) step(1'b0, '0, 8'h0, 1'b0, 1'b1);
      check("seq_word_count", xfers, 64);
      check("seq_overflow", overflow, 0);

      // Memory stalled: four words fill the FIFO, the fifth is dropped.
      do_reset();
      for (int i = 0; i < 20; i++) step(1'b1, AW'(i), 8'(~i), 1'b0, 1'b0);
      check("stall_overflow_set", overflow, 1);
      xfers = 0;
      for (int i = 0; i < 8; i++) step(1'b0, '0, 8'h0, 1'b0, 1'b1);
      check("stall_word_count", xfers, 4);
      check("stall_overflow_sticky", overflow, 1);

      // Reset with two words queued, then a fresh run.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b1, AW'(i), 8'(i + 7), 1'b0, 1'b0);
      check("pre_rst_valid", mem_valid, 1);
      do_reset();
      check("post_rst_valid", mem_valid, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_overflow", overflow, 0);
      xfers = 0;
      for (int i = 0; i < 4; i++) step(1'b1, AW'(32'h100 + i), 8'(i + 1), 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 8'h0, 1'b0, 1'b1);
      check("post_rst_words", xfers, 1);

      // Randomized traffic against the model: one block with memory mostly
      // ready, one with long stall windows to provoke drops.
      for (int blk = 0; blk < 2; blk++) begin
         do_reset();
         seq = AW'($urandom_range(0, 4095));
         for (int i = 0; i < 1000; i++) begin
            logic [AW-1:0] pa;
            logic          rdy;
            r = $urandom_range(0, 9);
            if (r < 6) begin
               pa  = seq;
               seq = seq + 1;
            end else if (r < 8) begin
               pa = {seq[AW-1:2], 2'($urandom_range(0, 3))};
            end else begin
               pa = AW'($urandom);
            end
            if (blk == 0) rdy = ($urandom_range(0, 7) != 0);
            else          rdy = ((i % 150) >= 40) && ($urandom_range(0, 3) != 0);
            step(($urandom_range(0, 3) != 0), pa, 8'($urandom),
                 ($urandom_range(0, 40) == 0), rdy);
         end
         for (int i = 0; i < 12; i++) step(1'b0, '0, 8'h0, 1'b0, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pixel_pack_writer.md
PIXEL_PACK_WRITER -- requirements
Module: pixel_pack_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of packed words buffered toward memory (power of two, >=2).
REQ-002 Parameter ADDR_W, default 32, width of the pixel byte address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pix_valid  input  1  one output pixel presented this cycle (driven by the core's wr_valid; cannot be stalled).
REQ-006 pix_addr  input  ADDR_W  byte address of the pixel in the output image.
REQ-007 pix_data  input  8  pixel value.
REQ-008 flush  input  1  one-cycle pulse (driven by the core's done); emit any partial word, then drain.
REQ-009 mem_valid  output  1  packed word available at FIFO head.
REQ-010 mem_ready  input  1  memory accepts the word; transfer when mem_valid && mem_ready.
REQ-011 mem_addr  output  ADDR_W-2  word address (pix_addr[ADDR_W-1:2]).
REQ-012 mem_data  output  32  packed bytes, lane k in bits [8k+7:8k], little-endian.
REQ-013 mem_be  output  4  byte enables, bit k set iff lane k was written.
REQ-014 busy  output  1  high when state != RUN, or when the pack buffer or FIFO is non-empty.
REQ-015 flushed  output  1  one-cycle pulse when the flush drain completes.
REQ-016 overflow  output  1  sticky; set when a word or pixel is dropped; cleared only by reset.

Function
REQ-017 Pack buffer holds: word address, 4 data bytes, 4-bit mask; empty when mask==0.
REQ-018 In RUN with pix_valid and empty buffer: load word address, write lane pix_addr[1:0], set that mask bit.
REQ-019 In RUN with pix_valid and matching word address: write that lane; a repeated lane is overwritten by the newer byte.
REQ-020 In RUN with pix_valid and a different word address: push the old buffer to the FIFO, then load the new pixel alone.
REQ-021 When the updated mask becomes 4'hF: push that same cycle; the buffer is empty next cycle.
REQ-022 At most one FIFO push occurs per cycle (rules 020/021 are mutually exclusive).
REQ-023 If a push is required while the FIFO is full and no pop happens that cycle: drop the word and set overflow.
REQ-024 Simultaneous push and pop on a full FIFO is legal; the occupancy count is unchanged.
REQ-025 FIFO is first-word-fall-through. A word pushed at edge N shows mem_valid=1 from cycle N+1.
REQ-026 mem_addr, mem_data and mem_be stay stable while mem_valid && !mem_ready.
REQ-027 State machine RUN/FLUSH/DRAIN. RUN->FLUSH on flush; the pixel in that same cycle is still handled under RUN rules.
REQ-028 FLUSH: if the buffer is empty, or the FIFO is not full (or pops this cycle), push any partial buffer and move to DRAIN; otherwise hold.
REQ-029 DRAIN: when the FIFO is empty, pulse flushed for one cycle and return to RUN.
REQ-030 pix_valid in FLUSH or DRAIN: pixel dropped, overflow set. flush while not in RUN: ignored.

Reset
REQ-031 rst_n low: state=RUN; buffer mask, FIFO pointers and FIFO count=0; mem_valid=0, mem_addr=0, mem_data=0, mem_be=0, busy=0, flushed=0, overflow=0.
REQ-032 Reset mid-operation discards buffered and queued words with no memory transfer; first cycle after release behaves as idle RUN.

Structure
REQ-033 Shared package downscale_pkg holds the state enum typedef (RUN, FLUSH, DRAIN), the default FIFO depth, and the packed-word struct (addr, data, be).
REQ-034 FIFO is a sub-module sync_fifo (parameterised width/depth, FWFT, full/empty/count); the packing logic and FSM live in pixel_pack_writer.

Verification
REQ-035 256 sequential pixels, addr 0..255, data=addr, mem_ready=1 -> 64 words, addr 0..63, be=4'hF, word 0 data=32'h03020100; mem_valid rises one cycle after the 4th byte; overflow=0.
REQ-036 Pixels at addr 0 (0x11) and 1 (0x22), then flush -> one word addr 0, be=4'b0011, data[15:0]=16'h2211; flushed pulses after the accept; busy then 0.
REQ-037 Addr 5 (0xAA) then addr 12 (0xBB) -> at the second pixel, push word addr 1, be=4'b0010, data[15:8]=0xAA; buffer holds word 3, be=4'b0001.
REQ-038 mem_ready=0, 20 sequential pixels (5 words) -> FIFO holds 4, 5th dropped, overflow=1; mem_ready=1 -> exactly words 0..3 emitted; overflow stays 1.
REQ-039 Addr 3 data 0xAA then addr 3 data 0xBB, then flush -> word addr 0, be=4'b1000, data[31:24]=0xBB.
REQ-040 rst_n low for 1 cycle with 2 words queued and mem_ready=0 -> after release mem_valid=0, busy=0, overflow=0; a new 4-pixel run emits normally.
